// File: rtl/uart_instr_loader_if.sv
// rtl/uart_instr_loader_if.sv - UART byte stream, response byte and memory write bus of the instruction loader
//
// Signals:
//   rx_data/rx_valid   received byte and its one-cycle strobe
//   tx_data/tx_valid   ACK/NAK response byte, held until tx_ready
//   tx_ready           transmitter accepts the response byte
//   wr_en/wr_addr/wr_data  instruction memory write port
// Modports:
//   master  the loader (drives response and memory write)
//   slave   the surrounding system (drives rx stream and tx_ready)
interface uart_instr_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, wr_en, wr_addr, wr_data
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/uart_instr_loader.sv
// rtl/uart_instr_loader.sv - decodes framed UART load packets into instruction memory writes
//
// Packet: SYNC, ADDR, COUNT, COUNT x 4 data bytes (big-endian words), CHK.
// COUNT=0 means 256 words; CHK is the 8-bit sum of ADDR, COUNT and all data bytes.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   bus           rx stream in, ACK/NAK byte out, memory write port out
//   mem_ext_en    loader owns instruction memory (control FSM must stall)
//   busy          loader is inside a packet or response
//   load_done     one-cycle pulse on a packet with a good checksum
//   chk_err       sticky bad-checksum flag, cleared by the next SYNC
//   timeout_err   sticky inter-byte timeout flag, cleared by the next SYNC
//   words_loaded  words written in the current/last packet
module uart_instr_loader #(
    parameter int         INSTR_WIDTH    = 32,
    parameter int         INSTR_DEPTH    = 256,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    localparam int        ADDR_W         = $clog2(INSTR_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_instr_loader_if.master    bus,
    output logic                   mem_ext_en,
    output logic                   busy,
    output logic                   load_done,
    output logic                   chk_err,
    output logic                   timeout_err,
    output logic [8:0]             words_loaded
);
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam int         TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // The counter reaching this value with another idle cycle is the TIMEOUT_CYCLES-th idle clock.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_COUNT, GET_DATA, GET_CHK, RESPOND
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        words_left;
    logic [23:0]       asm_q;      // first three bytes of the word being assembled
    logic [1:0]        byte_idx;
    logic [7:0]        sum;
    logic [TMO_W-1:0]  tmo_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            words_left   <= '0;
            asm_q        <= '0;
            byte_idx     <= '0;
            sum          <= '0;
            tmo_cnt      <= '0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            mem_ext_en   <= 1'b0;
            load_done    <= 1'b0;
            chk_err      <= 1'b0;
            timeout_err  <= 1'b0;
            words_loaded <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                        state        <= GET_ADDR;
                        mem_ext_en   <= 1'b1;
                        chk_err      <= 1'b0;
                        timeout_err  <= 1'b0;
                        words_loaded <= '0;
                        sum          <= '0;
                        tmo_cnt      <= '0;
                        byte_idx     <= '0;
                    end
                end
                RESPOND: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        mem_ext_en   <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    if (bus.rx_valid) begin
                        tmo_cnt <= '0;
                        case (state)
                            GET_ADDR: begin
                                addr  <= bus.rx_data[ADDR_W-1:0];
                                sum   <= sum + bus.rx_data;
                                state <= GET_COUNT;
                            end
                            GET_COUNT: begin
                                words_left <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                                sum        <= sum + bus.rx_data;
                                state      <= GET_DATA;
                            end
                            GET_DATA: begin
                                sum      <= sum + bus.rx_data;
                                byte_idx <= byte_idx + 2'd1;
                                asm_q    <= {asm_q[15:0], bus.rx_data};
                                if (byte_idx == 2'd3) begin
                                    bus.wr_en    <= 1'b1;
                                    bus.wr_addr  <= addr;
                                    bus.wr_data  <= INSTR_WIDTH'({asm_q, bus.rx_data});
                                    addr         <= addr + 1'b1;
                                    words_loaded <= words_loaded + 9'd1;
                                    words_left   <= words_left - 9'd1;
                                    if (words_left == 9'd1) begin
                                        state <= GET_CHK;
                                    end
                                end
                            end
                            GET_CHK: begin
                                if (bus.rx_data == sum) begin
                                    load_done   <= 1'b1;
                                    bus.tx_data <= ACK;
                                end else begin
                                    chk_err     <= 1'b1;
                                    bus.tx_data <= NAK;
                                end
                                bus.tx_valid <= 1'b1;
                                state        <= RESPOND;
                            end
                            default: ;
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Any partially assembled word is simply abandoned.
                        timeout_err  <= 1'b1;
                        bus.tx_data  <= NAK;
                        bus.tx_valid <= 1'b1;
                        state        <= RESPOND;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/uart_instr_loader.md
Name: uart_instr_loader

Overview:
- Upstream feeder for tiny_fsm_control's instruction memory.
- Consumes a byte stream from the UART receiver and decodes a framed load packet (sync, start address, count, 32-bit instruction words, checksum).
- Writes each assembled word into instruction memory.
- Holds the control FSM off memory via mem_ext_en while loading, and returns an ACK/NAK byte to the UART transmitter.

Parameters:
- INSTR_WIDTH, 32, instruction word width. Fixed at 4 bytes per word.
- INSTR_DEPTH, 256, instruction memory depth. Address width is $clog2(INSTR_DEPTH).
- TIMEOUT_CYCLES, 50000, idle clocks allowed between bytes inside a packet. At 50 MHz this is 1 ms.
- SYNC_BYTE, 8'hA5, packet start marker.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- tx_data  out  8  response byte (8'h06 ACK / 8'h15 NAK).
- tx_valid  out  1  response byte valid; held until tx_ready.
- tx_ready  in  1  UART transmitter can accept a byte.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  $clog2(INSTR_DEPTH)  write address.
- wr_data  out  INSTR_WIDTH  write data.
- mem_ext_en  out  1  loader owns instruction memory; the control FSM must stall.
- busy  out  1  state != IDLE.
- load_done  out  1  one-cycle pulse when a packet completes with a good checksum.
- chk_err  out  1  sticky; cleared on next accepted SYNC.
- timeout_err  out  1  sticky; cleared on next accepted SYNC.
- words_loaded  out  9  words written in the current/last packet.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0, including wr_addr, wr_data, tx_data, words_loaded and all error flags.
- Packet format: SYNC, ADDR, COUNT, then COUNT×4 data bytes big-endian (first byte → bits [31:24]), then CHK.
  - COUNT=0 means 256 words.
  - CHK = 8-bit modular sum of ADDR, COUNT and all data bytes.
- States: IDLE → GET_ADDR → GET_COUNT → GET_DATA → GET_CHK → RESPOND → IDLE.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE → GET_ADDR. Clears chk_err, timeout_err, words_loaded and the running sum.
  - Any other byte is ignored.
- GET_ADDR: load the address counter; the byte is added to the sum.
- GET_COUNT: load the word counter; the byte is added to the sum.
- GET_DATA:
  - Shift bytes into a 32-bit assembler.
  - On the 4th byte: wr_en=1 for exactly one cycle on the next clock, with wr_addr=current address and wr_data=assembled word.
  - After the write, the address increments mod INSTR_DEPTH (255→0 wraps) and words_loaded increments.
  - After the last word → GET_CHK.
- GET_CHK:
  - Good checksum: load_done pulses; tx_data=8'h06.
  - Bad checksum: chk_err=1; tx_data=8'h15.
  - Both cases → RESPOND.
  - Words already written are not rolled back.
- RESPOND: tx_valid=1 until the cycle tx_ready=1, then → IDLE. rx bytes are ignored in this state.
- mem_ext_en:
  - Asserts the cycle after SYNC is accepted.
  - Deasserts on entry to IDLE.
  - Covers every wr_en.
- Timeout:
  - In GET_ADDR through GET_CHK, a counter increments every cycle without rx_valid and resets on rx_valid.
  - At TIMEOUT_CYCLES: timeout_err=1, tx_data=8'h15 → RESPOND. The partial word is discarded.
  - RESPOND does not time out.
- A SYNC_BYTE value inside a packet is treated as data; there is no resync.
- rx_valid is single-cycle; back-to-back bytes on consecutive cycles must be accepted without loss.
- Reset mid-packet: immediate return to IDLE with all outputs 0. No partial write is emitted.

Test Plan:
1. Packet A5,00,02, 80,00,00,01, 40,00,00,02, CHK=C5:
   - wr_en ×2: addr0=32'h80000001, addr1=32'h40000002.
   - load_done pulse; tx_data=06; words_loaded=2; mem_ext_en low after tx_ready.
2. Same packet with CHK=00:
   - Both words still written; chk_err=1; tx_data=15; no load_done.
3. Packet A5,FF,02 with two words:
   - Writes at addresses 255 then 0 (wrap).
4. A5,00,01,80,00, then silence for TIMEOUT_CYCLES (set to 100 in bench):
   - No wr_en; timeout_err=1; tx_data=15.
   - Next SYNC clears timeout_err.
5. Bytes 00,12,A5,10,01,C0,00,00,03,D4 with rx_valid on consecutive cycles:
   - Leading junk ignored.
   - One write: addr 0x10 = 32'hC0000003; ACK.
6. rst_n pulled low after the 3rd data byte:
   - All outputs 0 asynchronously; no wr_en.
   - A subsequent full packet loads correctly.
7. tx_ready held low 20 cycles in RESPOND:
   - tx_valid and tx_data stable for all 20 cycles.
   - Returns to IDLE one cycle after tx_ready.
